// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU port, external port and memory port.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
   parameter int AW = 9,
   parameter int DW = 18
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          cpu_stall;

   logic          ext_req;
   logic          ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
   logic [DW-1:0] ext_rdata;
   logic          ext_ack;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_stall,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_rdata, ext_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_stall,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_rdata, ext_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / external) arbiter onto a single-port data memory, 3-cycle occupancy.
// Define DMEM_ARB_STARVE_EN to force an external grant after STARVE_MAX contested CPU wins.
module dmem_arbiter #(
   parameter int AW         = 9,
   parameter int DW         = 18,
   parameter int STARVE_MAX = 4
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   localparam logic WIN_CPU = 1'b0;
   localparam logic WIN_EXT = 1'b1;

   logic [1:0]    state_q, state_d;
   logic          win_q, win_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;

   logic arb;
   logic grant_ext;
   logic issue;
   logic resp;

   // Requests are only looked at in IDLE; anything raised later waits its turn.
   assign arb = (state_q == IDLE) && (bus.cpu_req || bus.ext_req);

`ifdef DMEM_ARB_STARVE_EN
   localparam int              SW   = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] starve_q, starve_d;

   assign grant_ext = bus.ext_req && (!bus.cpu_req || (starve_q == SMAX));

   always_comb begin
      starve_d = starve_q;
      if (arb) begin
         if (grant_ext)
            starve_d = '0;
         else if (bus.ext_req && (starve_q != SMAX))
            starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) starve_q <= '0;
      else      starve_q <= starve_d;
   end
`else
   assign grant_ext = bus.ext_req && !bus.cpu_req;
`endif

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (arb) begin
               state_d = ISSUE;
               win_d   = grant_ext ? WIN_EXT : WIN_CPU;
               we_d    = grant_ext ? bus.ext_we    : bus.cpu_we;
               addr_d  = grant_ext ? bus.ext_addr  : bus.cpu_addr;
               wdata_d = grant_ext ? bus.ext_wdata : bus.cpu_wdata;
            end
         end
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         win_q   <= WIN_CPU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign issue = (state_q == ISSUE);
   assign resp  = (state_q == RESP);

   // Memory port is driven only during ISSUE so the bus idles at zero.
   assign bus.mem_en    = issue;
   assign bus.mem_we    = issue && we_q;
   assign bus.mem_addr  = issue ? addr_q  : '0;
   assign bus.mem_wdata = issue ? wdata_q : '0;

   assign bus.cpu_ack   = resp && (win_q == WIN_CPU);
   assign bus.ext_ack   = resp && (win_q == WIN_EXT);
   assign bus.cpu_rdata = bus.cpu_ack ? bus.mem_rdata : '0;
   assign bus.ext_rdata = bus.ext_ack ? bus.mem_rdata : '0;

   // Gated by reset so every output reads zero while rst is held low.
   assign bus.cpu_stall = rst && bus.cpu_req && !bus.cpu_ack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic against a
// transaction-level reference model (occupancy counter, shadow memory, grant log).
module tb_dmem_arbiter;
   localparam int AW   = 9;
   localparam int DW   = 18;
   localparam int SMAX = 4;
   localparam int MSZ  = 2 ** AW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   mem_init = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous RAM model: read data valid one cycle after mem_en (read-before-write).
   logic [DW-1:0] mem [MSZ];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MSZ; i++) mem[i] <= DW'(i * 37 + 5);
      end else if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: occ = cycles into the current access (0 none, 1 on memory, 2 ack).
   logic [DW-1:0] ref_mem [MSZ];
   int            occ = 0;
   int            starve = 0;
   bit            w_ext, w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wd, w_rd;
   bit            grants[$];
   bit            e_cack, e_eack;

   task automatic check_now();
      bit iss;
      iss    = (occ == 1);
      e_cack = (occ == 2) && !w_ext;
      e_eack = (occ == 2) && w_ext;
      chk("mem_en",    bus.mem_en,    iss);
      chk("mem_we",    bus.mem_we,    iss && w_we);
      chk("mem_addr",  bus.mem_addr,  iss ? w_addr : '0);
      chk("mem_wdata", bus.mem_wdata, iss ? w_wd : '0);
      chk("cpu_ack",   bus.cpu_ack,   e_cack);
      chk("ext_ack",   bus.ext_ack,   e_eack);
      chk("cpu_rdata", bus.cpu_rdata, e_cack ? w_rd : '0);
      chk("ext_rdata", bus.ext_rdata, e_eack ? w_rd : '0);
      chk("cpu_stall", bus.cpu_stall, rst && bus.cpu_req && !e_cack);
   endtask

   // Advance the model over the coming rising edge using the inputs now applied.
   task automatic adv();
      if (!rst) begin
         occ = 0;
         starve = 0;
         return;
      end
      case (occ)
         0: if (bus.cpu_req || bus.ext_req) begin
`ifdef DMEM_ARB_STARVE_EN
               w_ext = bus.ext_req && (!bus.cpu_req || starve >= SMAX);
               if (w_ext) starve = 0;
               else if (bus.ext_req && starve < SMAX) starve++;
`else
               w_ext = bus.ext_req && !bus.cpu_req;
`endif
               w_we   = w_ext ? bus.ext_we    : bus.cpu_we;
               w_addr = w_ext ? bus.ext_addr  : bus.cpu_addr;
               w_wd   = w_ext ? bus.ext_wdata : bus.cpu_wdata;
               grants.push_back(w_ext);
               occ = 1;
            end
         1: begin
            w_rd = ref_mem[w_addr];
            if (w_we) ref_mem[w_addr] = w_wd;
            occ = 2;
         end
         default: occ = 0;
      endcase
   endtask

   task automatic tick();
      adv();
      @(negedge clk);
      check_now();
   endtask

   task automatic new_cpu(bit we);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = AW'($urandom_range(MSZ - 1));
      bus.cpu_wdata = DW'($urandom);
   endtask

   task automatic new_ext(bit we);
      bus.ext_req   = 1'b1;
      bus.ext_we    = we;
      bus.ext_addr  = AW'($urandom_range(MSZ - 1));
      bus.ext_wdata = DW'($urandom);
   endtask

   // Requester behaviour: on ack either drop req or (keep) present a fresh request.
   task automatic drv(int pc, int pe, bit kc, bit ke);
      if (e_cack) begin
         if (kc) new_cpu(1'($urandom_range(1))); else bus.cpu_req = 1'b0;
      end else if (!bus.cpu_req && $urandom_range(99) < pc) new_cpu(1'($urandom_range(1)));
      if (e_eack) begin
         if (ke) new_ext(1'($urandom_range(1))); else bus.ext_req = 1'b0;
      end else if (!bus.ext_req && $urandom_range(99) < pe) new_ext(1'($urandom_range(1)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, pc, pe;
      bit kc, ke;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
      for (int i = 0; i < MSZ; i++) ref_mem[i] = DW'(i * 37 + 5);

      // Reset with both requests high: every output must stay zero.
      @(negedge clk);
      mem_init = 1'b1;
      bus.cpu_req = 1'b1;
      bus.ext_req = 1'b1;
      repeat (3) tick();
      mem_init = 1'b0;
      bus.cpu_req = 1'b0;
      bus.ext_req = 1'b0;
      rst = 1'b1;
      tick();

      // External write of 0x2ABCD to 0x05, then CPU read of it.
      bus.ext_we = 1; bus.ext_addr = 9'h005; bus.ext_wdata = 18'h2ABCD; bus.ext_req = 1;
      tick(); tick();
      chk("ext_ack_w5", bus.ext_ack, 1);
      bus.ext_req = 0;
      tick();
      bus.cpu_we = 0; bus.cpu_addr = 9'h005; bus.cpu_req = 1;
      #1 chk("c0_stall", bus.cpu_stall, 1);
      tick();
      chk("c1_en", bus.mem_en, 1);
      chk("c1_addr", bus.mem_addr, 9'h005);
      chk("c1_stall", bus.cpu_stall, 1);
      tick();
      chk("c2_ack", bus.cpu_ack, 1);
      chk("c2_rdata", bus.cpu_rdata, 18'h2ABCD);
      chk("c2_stall", bus.cpu_stall, 0);
      bus.cpu_req = 0;
      tick();

      // External write at the top of the address and data range, read back by CPU.
      bus.ext_we = 1; bus.ext_addr = 9'h1FF; bus.ext_wdata = 18'h3FFFF; bus.ext_req = 1;
      tick();
      chk("e_iss_we", bus.mem_we, 1);
      chk("e_iss_wd", bus.mem_wdata, 18'h3FFFF);
      tick();
      chk("e_ack", bus.ext_ack, 1);
      bus.ext_req = 0;
      tick();
      bus.cpu_we = 0; bus.cpu_addr = 9'h1FF; bus.cpu_req = 1;
      tick(); tick();
      chk("rb_1ff", bus.cpu_rdata, 18'h3FFFF);
      bus.cpu_req = 0;
      tick();

      // External request raised mid-access waits for the next IDLE.
      new_cpu(0);
      tick();
      new_ext(0);
      tick();
      chk("late_ext_rd", bus.ext_rdata, 0);
      chk("late_ext_ack", bus.ext_ack, 0);
      bus.cpu_req = 0;
      tick();
      chk("late_idle_en", bus.mem_en, 0);
      tick();
      chk("late_ext_addr", bus.mem_addr, bus.ext_addr);
      tick();
      chk("late_ext_ack2", bus.ext_ack, 1);
      bus.ext_req = 0;
      tick();

      // Reset during ISSUE of a CPU write aborts it; held request is re-granted.
      new_cpu(1);
      tick();
      chk("abort_iss_we", bus.mem_we, 1);
      #2 rst = 1'b0;
      #1;
      chk("abort_en", bus.mem_en, 0);
      chk("abort_we", bus.mem_we, 0);
      chk("abort_addr", bus.mem_addr, 0);
      chk("abort_wd", bus.mem_wdata, 0);
      chk("abort_stall", bus.cpu_stall, 0);
      chk("abort_ack", bus.cpu_ack, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("regrant_en", bus.mem_en, 1);
      tick();
      chk("regrant_ack", bus.cpu_ack, 1);
      bus.cpu_req = 0;
      tick();

      // Both requesting continuously from a fresh reset.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      grants.delete();
      new_cpu(0);
      new_ext(1);
      repeat (30) begin tick(); drv(0, 0, 1, 1); end
      chk("cont_ngrants", grants.size(), 10);
      for (int i = 0; i < grants.size(); i++) begin
`ifdef DMEM_ARB_STARVE_EN
         chk("grant_order", grants[i], (i % 5 == 4));
`else
         chk("grant_order", grants[i], 0);
`endif
      end
      // CPU stops requesting after its next ack; external goes next.
      n0 = grants.size();
      repeat (6) begin tick(); drv(0, 0, 0, 1); end
      chk("drop_ngrants", grants.size() - n0, 2);
      chk("drop_g0_cpu", grants[n0], 0);
      chk("drop_g1_ext", grants[n0 + 1], 1);
      repeat (6) begin tick(); drv(0, 0, 0, 0); end

      // Randomized traffic.
      for (int blk = 0; blk < 15; blk++) begin
         pc = $urandom_range(10, 90);
         pe = $urandom_range(10, 90);
         kc = 1'($urandom_range(1));
         ke = 1'($urandom_range(1));
         repeat (200) begin tick(); drv(pc, pe, kc, ke); end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
